// File: rtl/aud_pkg.sv
//------------------------------------------------------------------------------
// Module : aud_pkg
// Brief  : Shared audio sample/frame types and LRCK slot constants.
// Rev    : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package aud_pkg;

  localparam int AUD_DATA_W = 16;

  typedef logic signed [AUD_DATA_W-1:0] sample_t;

  typedef struct packed {
    sample_t left;
    sample_t right;
  } frame_t;

  localparam logic LRCK_LEFT  = 1'b0;
  localparam logic LRCK_RIGHT = 1'b1;

endpackage

`default_nettype wire

// File: rtl/aud_tx_fifo.sv
//------------------------------------------------------------------------------
// Module : aud_tx_fifo
// Brief  : Single-clock first-word-fall-through frame FIFO with level count.
// Rev    : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module aud_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     i_AUD_BCLK,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;

  // Storage is not reset: clearing the pointers is enough to discard contents.
  always_ff @(posedge i_AUD_BCLK) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      o_level  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   o_level <= o_level + 1'b1;
        2'b01:   o_level <= o_level - 1'b1;
        default: o_level <= o_level;
      endcase
    end
  end

  assign o_rd_data = r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/aud_i2s_tx.sv
//------------------------------------------------------------------------------
// Module : aud_i2s_tx
// Brief  : I2S DAC transmitter with frame FIFO; AUD_TX_HOLD_LAST_EN repeats the
//          last popped frame on underrun instead of sending silence.
// Rev    : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module aud_i2s_tx
  import aud_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 16
) (
  input  logic                          i_AUD_BCLK,
  input  logic                          i_rst_n,
  input  logic                          i_daclrck,
  input  logic                          i_valid,
  input  logic signed [DATA_W-1:0]      i_left,
  input  logic signed [DATA_W-1:0]      i_right,
  output logic                          o_ready,
  input  logic                          i_mute,
  input  logic                          i_clr_underrun,
  output logic                          o_dacdat,
  output logic                          o_underrun,
  output logic [$clog2(FIFO_DEPTH):0]   o_level
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic                r_lrck;
  logic [DATA_W-1:0]   r_shift;
  logic [DATA_W-1:0]   r_right_hold;
  logic [CNT_W-1:0]    r_bit_cnt;

  logic                w_push;
  logic                w_pop;
  logic                w_edge;
  logic                w_left_start;
  logic                w_underrun_evt;
  logic [2*DATA_W-1:0] w_fifo_data;
  logic [2*DATA_W-1:0] w_under_data;
  logic [2*DATA_W-1:0] w_frame;
  logic [DATA_W-1:0]   w_load_word;

  assign o_ready        = (o_level < LVL_W'(FIFO_DEPTH));
  assign w_push         = i_valid && o_ready;
  assign w_edge         = (i_daclrck != r_lrck);
  assign w_left_start   = w_edge && (i_daclrck == LRCK_LEFT);
  assign w_pop          = w_left_start && (o_level != '0);
  assign w_underrun_evt = w_left_start && (o_level == '0);

  aud_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (2*DATA_W)
  ) u_fifo (
    .i_AUD_BCLK (i_AUD_BCLK),
    .i_rst_n    (i_rst_n),
    .i_push     (w_push),
    .i_wr_data  ({i_left, i_right}),
    .i_pop      (w_pop),
    .o_rd_data  (w_fifo_data),
    .o_level    (o_level)
  );

`ifdef AUD_TX_HOLD_LAST_EN
  logic [2*DATA_W-1:0] r_last;

  always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
    if (!i_rst_n)   r_last <= '0;
    else if (w_pop) r_last <= w_fifo_data;
  end

  assign w_under_data = r_last;
`else
  assign w_under_data = '0;
`endif

  assign w_frame     = (o_level != '0) ? w_fifo_data : w_under_data;
  // The right word is captured unmuted; mute is applied when it is actually loaded.
  assign w_load_word = i_mute                    ? '0           :
                       (i_daclrck == LRCK_RIGHT) ? r_right_hold :
                                                   w_frame[2*DATA_W-1:DATA_W];

  always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lrck       <= LRCK_LEFT;
      r_shift      <= '0;
      r_right_hold <= '0;
      r_bit_cnt    <= CNT_W'(DATA_W);
      o_dacdat     <= 1'b0;
      o_underrun   <= 1'b0;
    end else begin
      r_lrck <= i_daclrck;
      if (w_left_start) r_right_hold <= w_frame[DATA_W-1:0];

      // r_bit_cnt counts bits already driven; DATA_W means the slot is finished.
      if (w_edge) begin
        o_dacdat  <= w_load_word[DATA_W-1];
        r_shift   <= {w_load_word[DATA_W-2:0], 1'b0};
        r_bit_cnt <= CNT_W'(1);
      end else if (r_bit_cnt < CNT_W'(DATA_W)) begin
        o_dacdat  <= r_shift[DATA_W-1];
        r_shift   <= {r_shift[DATA_W-2:0], 1'b0};
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end else begin
        o_dacdat  <= 1'b0;
      end

      if (w_underrun_evt)      o_underrun <= 1'b1;
      else if (i_clr_underrun) o_underrun <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_aud_i2s_tx.sv
//------------------------------------------------------------------------------
// Module : tb_aud_i2s_tx
// Brief  : Directed plus randomized bench for aud_i2s_tx against a frame-queue model.
// Rev    : 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_aud_i2s_tx;
  import aud_pkg::*;

  localparam int FIFO_DEPTH = 4;
  localparam int DATA_W     = 16;

  logic                     clk   = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     lrck  = 1'b0;
  logic                     valid = 1'b0;
  logic                     mute  = 1'b0;
  logic                     clr   = 1'b0;
  logic signed [DATA_W-1:0] left  = '0;
  logic signed [DATA_W-1:0] right = '0;
  logic                     ready;
  logic                     dac;
  logic                     under;
  logic [2:0]               level;

  always #5 clk = ~clk;

  aud_i2s_tx #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_W     (DATA_W)
  ) dut (
    .i_AUD_BCLK     (clk),
    .i_rst_n        (rst_n),
    .i_daclrck      (lrck),
    .i_valid        (valid),
    .i_left         (left),
    .i_right        (right),
    .o_ready        (ready),
    .i_mute         (mute),
    .i_clr_underrun (clr),
    .o_dacdat       (dac),
    .o_underrun     (under),
    .o_level        (level)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: queue of frames, pending serial bits, sticky flag.
  frame_t      m_q[$];
  frame_t      m_last;
  sample_t     m_right;
  logic        m_lrck;
  logic        m_under;
  logic        m_bits[$];

`ifdef AUD_TX_HOLD_LAST_EN
  localparam logic HOLD = 1'b1;
`else
  localparam logic HOLD = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic m_reset();
    m_q.delete();
    m_bits.delete();
    m_last  = '0;
    m_right = '0;
    m_lrck  = LRCK_LEFT;
    m_under = 1'b0;
  endtask

  // One BCLK cycle: predict, clock, then compare all outputs.
  task automatic cyc(input logic v, input logic [15:0] l, input logic [15:0] r);
    frame_t      fr;
    frame_t      nf;
    logic [15:0] word;
    logic        edge_det, pop, push, uevt, exp_dac;
    valid = v; left = l; right = r;
    edge_det = (lrck != m_lrck);
    pop = 1'b0; uevt = 1'b0; word = '0; fr = '0;
    if (edge_det && lrck == LRCK_LEFT) begin
      if (m_q.size() > 0) begin
        fr = m_q[0]; pop = 1'b1; m_last = fr;
      end else begin
        uevt = 1'b1;
        fr = HOLD ? m_last : '0;
      end
      m_right = fr.right;
      word = mute ? '0 : fr.left;
    end else if (edge_det) begin
      word = mute ? '0 : m_right;
    end
    push = v && (m_q.size() < FIFO_DEPTH);
    if (pop) void'(m_q.pop_front());
    if (push) begin
      nf.left = l; nf.right = r;
      m_q.push_back(nf);
    end
    if (uevt)     m_under = 1'b1;
    else if (clr) m_under = 1'b0;
    if (edge_det) begin
      m_bits.delete();
      for (int i = DATA_W-1; i >= 0; i--) m_bits.push_back(word[i]);
    end
    exp_dac = (m_bits.size() > 0) ? m_bits.pop_front() : 1'b0;
    m_lrck = lrck;
    @(posedge clk); #1;
    chk("dacdat",   {31'd0, dac},   {31'd0, exp_dac});
    chk("level",    {29'd0, level}, m_q.size());
    chk("ready",    {31'd0, ready}, {31'd0, (m_q.size() < FIFO_DEPTH)});
    chk("underrun", {31'd0, under}, {31'd0, m_under});
    valid = 1'b0;
  endtask

  task automatic slot(input logic lr, input int n, output logic [15:0] bits);
    lrck = lr;
    bits = '0;
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, '0, '0);
      bits = {bits[14:0], dac};
    end
  endtask

  logic [15:0] bits;
  logic [2:0]  lvl_before;
  int          half;
  int          hl;

  initial begin
    m_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dacdat",   {31'd0, dac},   32'd0);
    chk("rst_level",    {29'd0, level}, 32'd0);
    chk("rst_ready",    {31'd0, ready}, 32'd1);
    chk("rst_underrun", {31'd0, under}, 32'd0);
    rst_n = 1'b1;

    // One frame over a full LRCK period, MSB first.
    cyc(1'b1, 16'h8001, 16'h7FFE);
    slot(1'b1, 16, bits); chk("right_idle", {16'd0, bits}, 32'h0);
    slot(1'b0, 16, bits); chk("left_8001",  {16'd0, bits}, 32'h8001);
    slot(1'b1, 16, bits); chk("right_7ffe", {16'd0, bits}, 32'h7FFE);

    // Underrun after a 1234/5678 frame, then clear.
    cyc(1'b1, 16'h1234, 16'h5678);
    slot(1'b0, 16, bits); slot(1'b1, 16, bits);
    slot(1'b0, 16, bits);
    chk("under_flag",  {31'd0, under}, 32'd1);
    chk("under_left",  {16'd0, bits}, HOLD ? 32'h1234 : 32'h0);
    slot(1'b1, 16, bits);
    chk("under_right", {16'd0, bits}, HOLD ? 32'h5678 : 32'h0);
    clr = 1'b1; cyc(1'b0, '0, '0); clr = 1'b0;
    chk("under_clr", {31'd0, under}, 32'd0);

    // Fill with five pushes and no LRCK edges.
    for (int i = 0; i < 5; i++) cyc(1'b1, 16'(16'h1000 + i), 16'(16'h2000 + i));
    chk("full_ready", {31'd0, ready}, 32'd0);
    chk("full_level", {29'd0, level}, 32'd4);

    // Push refused while full on a left-start pop.
    lrck = 1'b0; cyc(1'b1, 16'hAAAA, 16'h5555);
    chk("full_pop_level", {29'd0, level}, 32'd3);
    slot(1'b0, 15, bits); slot(1'b1, 16, bits);
    slot(1'b0, 16, bits); slot(1'b1, 16, bits);
    chk("level_two", {29'd0, level}, 32'd2);
    lrck = 1'b0; cyc(1'b1, 16'hBBBB, 16'hCCCC);
    chk("pushpop_level", {29'd0, level}, 32'd2);
    slot(1'b0, 15, bits);

    // Drain, then mute a full-scale frame.
    for (int k = 0; k < 5; k++) begin
      slot(1'b1, 16, bits); slot(1'b0, 16, bits);
    end
    chk("drained", {29'd0, level}, 32'd0);
    cyc(1'b1, 16'hFFFF, 16'hFFFF);
    mute = 1'b1;
    slot(1'b1, 16, bits); chk("mute_right0", {16'd0, bits}, 32'h0);
    lvl_before = level;
    slot(1'b0, 16, bits); chk("mute_left",   {16'd0, bits}, 32'h0);
    chk("mute_pop", {29'd0, level}, {29'd0, lvl_before - 3'd1});
    slot(1'b1, 16, bits); chk("mute_right",  {16'd0, bits}, 32'h0);
    mute = 1'b0;

    // Randomized traffic with occasional short (aborting) slots.
    half = 0; hl = 16;
    for (int c = 0; c < 800; c++) begin
      if (half >= hl) begin
        lrck = ~lrck; half = 0;
        hl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(3, 15)) : 16;
      end
      mute = ($urandom_range(0, 9) == 0);
      clr  = ($urandom_range(0, 9) == 0);
      cyc(($urandom_range(0, 19) == 0), 16'($urandom), 16'($urandom));
      half++;
    end
    mute = 1'b0; clr = 1'b0;

    // Reset in the middle of a left word.
    if (lrck == 1'b0) slot(1'b1, 16, bits);
    cyc(1'b1, 16'hC3A5, 16'h0F0F);
    slot(1'b0, 8, bits);
    rst_n = 1'b0;
    #1;
    chk("midrst_dacdat",   {31'd0, dac},   32'd0);
    chk("midrst_level",    {29'd0, level}, 32'd0);
    chk("midrst_ready",    {31'd0, ready}, 32'd1);
    chk("midrst_underrun", {31'd0, under}, 32'd0);
    m_reset();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    slot(1'b0, 4, bits);  chk("post_rst_idle",  {16'd0, bits}, 32'h0);
    cyc(1'b1, 16'h9C3E, 16'h4D21);
    slot(1'b1, 16, bits); chk("post_rst_right", {16'd0, bits}, 32'h0);
    slot(1'b0, 16, bits); chk("post_rst_left",  {16'd0, bits}, 32'h9C3E);
    slot(1'b1, 16, bits); chk("post_rst_r2",    {16'd0, bits}, 32'h4D21);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
